// File: rtl/fan_pkg.sv
// Shared definitions for the FAN issue controller: ctrl bit positions and
// the lane line layout {ctrl, row, data}.
package fan_pkg;

    localparam int CTRL_VALID   = 0;
    localparam int CTRL_JOIN_L  = 1;
    localparam int CTRL_JOIN_R  = 2;
    localparam int CTRL_ROW_END = 3;

    function automatic int line_w(input int dw_data, input int dw_row, input int dw_ctrl);
        return dw_data + dw_row + dw_ctrl;
    endfunction

    function automatic int row_off(input int dw_data);
        return dw_data;
    endfunction

    function automatic int ctrl_off(input int dw_data, input int dw_row);
        return dw_data + dw_row;
    endfunction

endpackage

// File: rtl/fan_out_fifo.sv
// First-word fall-through FIFO over a registered array; head reads 0 when
// empty so the output bus is quiet between results.
module fan_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_d, mem_q;
    logic [AW-1:0]           wr_d, wr_q, rd_d, rd_q;
    logic [AW:0]             cnt_d, cnt_q;
    logic                    do_push, do_pop;

    assign do_pop  = pop & (cnt_q != '0);
    assign do_push = push & ((cnt_q != (AW+1)'(DEPTH)) | do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop)
            rd_d = rd_q + 1'b1;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count = cnt_q;

endmodule

// File: rtl/fan_issue_ctrl.sv
// Issue controller for the FAN reduction network: encodes per-lane adder ctrl,
// tracks the fixed-latency pipe and admits vectors only with guaranteed FIFO space.
module fan_issue_ctrl
    import fan_pkg::*;
#(
    parameter int NUM_IN    = 32,
    parameter int DW_DATA   = 32,
    parameter int DW_ROW    = 4,
    parameter int DW_CTRL   = 4,
    parameter int FAN_LAT   = 4,
    parameter int OUT_DEPTH = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [NUM_IN*DW_DATA-1:0]                             in_data,
    input  logic [NUM_IN*DW_ROW-1:0]                              in_row,
    input  logic [NUM_IN-1:0]                                     in_mask,
    output logic [NUM_IN*line_w(DW_DATA, DW_ROW, DW_CTRL)-1:0]    fan_in,
    input  logic [NUM_IN*line_w(DW_DATA, DW_ROW, DW_CTRL)-1:0]    fan_out,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [NUM_IN*DW_DATA-1:0]                             out_data,
    output logic [NUM_IN*DW_ROW-1:0]                              out_row,
    output logic [NUM_IN-1:0]                                     out_last,
    output logic                                                  busy
);
    localparam int DW_LINE  = line_w(DW_DATA, DW_ROW, DW_CTRL);
    localparam int ROW_OFF  = row_off(DW_DATA);
    localparam int CTRL_OFF = ctrl_off(DW_DATA, DW_ROW);
    localparam int CW       = $clog2(OUT_DEPTH) + 1;

    logic [NUM_IN-1:0][DW_LINE-1:0] enc_line, fan_in_d, fan_in_q, head;
    logic [NUM_IN-1:0][DW_CTRL-1:0] unused_ctrl;
    logic [FAN_LAT:0]               vld_pipe_d, vld_pipe_q;
    logic [CW-1:0]                  inflight_d, inflight_q, fifo_count;
    logic [CW:0]                    credit_used;
    logic                           issue, push, pop;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_enc
        logic [DW_ROW-1:0]  row_i;
        logic               join_l, join_r;
        logic [DW_CTRL-1:0] ctrl;

        assign row_i = in_row[i*DW_ROW +: DW_ROW];

        if (i == 0) begin : g_no_left
            assign join_l = 1'b0;
        end else begin : g_left
            assign join_l = in_mask[i] & in_mask[i-1] &
                            (row_i == in_row[(i-1)*DW_ROW +: DW_ROW]);
        end

        if (i == NUM_IN-1) begin : g_no_right
            assign join_r = 1'b0;
        end else begin : g_right
            assign join_r = in_mask[i] & in_mask[i+1] &
                            (row_i == in_row[(i+1)*DW_ROW +: DW_ROW]);
        end

        always_comb begin
            ctrl               = '0;
            ctrl[CTRL_VALID]   = in_mask[i];
            ctrl[CTRL_JOIN_L]  = join_l;
            ctrl[CTRL_JOIN_R]  = join_r;
            ctrl[CTRL_ROW_END] = in_mask[i] & ~join_r;
        end

        assign enc_line[i] = {ctrl, row_i, in_data[i*DW_DATA +: DW_DATA]};
    end

    // Every accepted-but-unpopped vector holds a credit, so the FAN can never
    // deliver into a full FIFO.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign in_ready    = rst & (credit_used < (CW+1)'(OUT_DEPTH));
    assign issue       = in_valid & in_ready & (|in_mask);
    assign push        = vld_pipe_q[FAN_LAT];
    assign pop         = out_valid & out_ready;

    always_comb begin
        fan_in_d   = issue ? enc_line : '0;
        vld_pipe_d = {vld_pipe_q[FAN_LAT-1:0], issue};
        inflight_d = inflight_q + CW'(issue) - CW'(push);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fan_in_q   <= '0;
            vld_pipe_q <= '0;
            inflight_q <= '0;
        end else begin
            fan_in_q   <= fan_in_d;
            vld_pipe_q <= vld_pipe_d;
            inflight_q <= inflight_d;
        end
    end

    fan_out_fifo #(
        .W     (NUM_IN*DW_LINE),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fan_out),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    for (genvar i = 0; i < NUM_IN; i++) begin : g_out
        assign out_data[i*DW_DATA +: DW_DATA] = head[i][DW_DATA-1:0];
        assign out_row[i*DW_ROW +: DW_ROW]    = head[i][ROW_OFF +: DW_ROW];
        assign out_last[i]                    = head[i][CTRL_OFF + CTRL_ROW_END];
        assign unused_ctrl[i]                 = head[i][CTRL_OFF +: DW_CTRL];
    end

    assign fan_in    = fan_in_q;
    assign out_valid = (fifo_count != '0);
    assign busy      = (inflight_q != '0) | (fifo_count != '0);

endmodule

// File: tb/tb_fan_issue_ctrl.sv
// Bench for fan_issue_ctrl: FAN modelled as a FAN_LAT-deep loopback, outputs
// checked against a scoreboard, ctrl encoding checked from a vector table.
module tb_fan_issue_ctrl;
    localparam int NUM_IN = 32, DW_DATA = 32, DW_ROW = 4, DW_CTRL = 4;
    localparam int FAN_LAT = 4, OUT_DEPTH = 8;
    localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
    localparam int LW = NUM_IN * DW_LINE;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid, in_ready, out_valid, out_ready, busy;
    logic [NUM_IN*DW_DATA-1:0]   in_data, out_data;
    logic [NUM_IN*DW_ROW-1:0]    in_row, out_row;
    logic [NUM_IN-1:0]           in_mask, out_last;
    logic [LW-1:0]               fan_in, fan_out;
    logic [LW-1:0]               dly [FAN_LAT];

    typedef struct {
        logic [NUM_IN*DW_DATA-1:0] data;
        logic [NUM_IN*DW_ROW-1:0]  row;
        logic [NUM_IN-1:0]         last;
    } exp_t;

    typedef struct {
        logic [31:0]  mask;
        logic [127:0] row;
        int           lane;
        logic [3:0]   ctrl;
    } vec_t;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0, n_out = 0, n_issued = 0;

    fan_issue_ctrl #(
        .NUM_IN(NUM_IN), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW), .DW_CTRL(DW_CTRL),
        .FAN_LAT(FAN_LAT), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_row(in_row), .in_mask(in_mask),
        .fan_in(fan_in), .fan_out(fan_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // FAN stand-in: fan_in sampled at edge t+1 reappears for the edge t+1+FAN_LAT.
    initial for (int i = 0; i < FAN_LAT; i++) dly[i] = '0;
    always @(posedge clk) begin
        dly[0] <= fan_in;
        for (int i = 1; i < FAN_LAT; i++) dly[i] <= dly[i-1];
    end
    assign fan_out = dly[FAN_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] enc(input logic [31:0] m, input logic [127:0] r, input int i);
        logic jl, jr;
        jl = 1'b0;
        jr = 1'b0;
        if (i > 0 && m[i] && m[i-1] && r[i*4 +: 4] == r[(i-1)*4 +: 4]) jl = 1'b1;
        if (i < NUM_IN-1 && m[i] && m[i+1] && r[i*4 +: 4] == r[(i+1)*4 +: 4]) jr = 1'b1;
        return {m[i] & ~jr, jr, jl, m[i]};
    endfunction

    function automatic exp_t mk_exp(input logic [NUM_IN*DW_DATA-1:0] d,
                                    input logic [127:0] r, input logic [31:0] m);
        exp_t e;
        logic [3:0] c;
        e.data = d;
        e.row  = r;
        for (int i = 0; i < NUM_IN; i++) begin
            c = enc(m, r, i);
            e.last[i] = c[3];
        end
        return e;
    endfunction

    // Scoreboard and per-cycle credit check, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        chk("in_ready_credit", in_ready, rst && (exp_q.size() < OUT_DEPTH));
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (out_data !== e.data || out_row !== e.row || out_last !== e.last) begin
                        n_fail++;
                        for (int l = 0; l < NUM_IN; l++)
                            if (out_data[l*32 +: 32] !== e.data[l*32 +: 32] ||
                                out_row[l*4 +: 4] !== e.row[l*4 +: 4] || out_last[l] !== e.last[l]) begin
                                $display("FAIL out_vec #%0d lane %0d: got d=%h r=%h l=%b want d=%h r=%h l=%b",
                                         n_out, l, out_data[l*32 +: 32], out_row[l*4 +: 4], out_last[l],
                                         e.data[l*32 +: 32], e.row[l*4 +: 4], e.last[l]);
                                break;
                            end
                    end
                    n_out++;
                end
            end
            if (in_valid && in_ready && in_mask != '0) begin
                exp_q.push_back(mk_exp(in_data, in_row, in_mask));
                n_issued++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_IN; i++) in_data[i*32 +: 32] = $urandom;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        vec_t         tbl[10];
        logic [127:0] rows_a, rows_same;
        int           lat, acc, k, cyc, seen;
        logic [15:0]  lfsr;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_row = '0; in_mask = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fan_in", |fan_in, 0);
        chk("rst_out_data", |{out_data, out_row, out_last}, 0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", in_ready, 1);
        out_ready = 1'b1;

        for (int i = 0; i < NUM_IN; i++) begin
            rows_same[i*4 +: 4] = 4'd5;
            rows_a[i*4 +: 4]    = (i < 2) ? 4'd0 : (i < 5) ? 4'd1 : 4'((i + 1) / 3);
        end
        tbl[0] = '{32'hFFFF_FFFF, rows_a, 0, 4'b0101};
        tbl[1] = '{32'hFFFF_FFFF, rows_a, 1, 4'b1011};
        tbl[2] = '{32'hFFFF_FFFF, rows_a, 2, 4'b0101};
        tbl[3] = '{32'hFFFF_FFFF, rows_a, 3, 4'b0111};
        tbl[4] = '{32'hFFFF_FFFF, rows_a, 4, 4'b1011};
        tbl[5] = '{32'h7FFF_FFFF, rows_same, 30, 4'b1011};
        tbl[6] = '{32'h7FFF_FFFF, rows_same, 31, 4'b0000};
        tbl[7] = '{32'hFFFF_FFFF, rows_same, 31, 4'b1011};
        tbl[8] = '{32'h0000_0080, rows_same, 7, 4'b1001};
        tbl[9] = '{32'h0000_0180, rows_same, 8, 4'b1011};

        for (int t = 0; t < 10; t++) begin
            in_valid = 1'b1;
            in_mask  = tbl[t].mask;
            in_row   = tbl[t].row;
            rand_data();
            step();
            in_valid = 1'b0;
            chk($sformatf("ctrl_t%0d_lane%0d", t, tbl[t].lane),
                fan_in[tbl[t].lane*DW_LINE + 36 +: 4], tbl[t].ctrl);
            if (t == 0) begin
                lat = 1;
                while (!out_valid && lat < 20) begin
                    step();
                    lat++;
                end
                chk("latency", lat, FAN_LAT + 2);
            end
            drain($sformatf("drain_t%0d", t));
        end

        // All-zero mask: handshake only, nothing issued.
        in_valid = 1'b1;
        in_mask  = '0;
        rand_data();
        for (int c = 0; c < 4; c++) begin
            chk("zero_ready", in_ready, 1);
            step();
            chk("zero_fan_in", |fan_in, 0);
            chk("zero_busy", busy, 0);
        end
        in_valid = 1'b0;
        seen = 0;
        repeat (8) begin
            step();
            if (out_valid) seen = 1;
        end
        chk("zero_no_out", seen, 0);

        // Backpressure: credits cap acceptance at OUT_DEPTH.
        out_ready = 1'b0;
        in_mask   = '1;
        in_row    = rows_a;
        acc       = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            rand_data();
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, OUT_DEPTH);
        chk("bp_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_ready_after_pop", in_ready, 1);
        step();
        chk("bp_ready_hold", in_ready, 1);
        drain("bp_drain");

        // Streaming with out_ready driven from an LFSR.
        lfsr = 16'hACE1;
        k    = 0;
        cyc  = 0;
        in_mask = $urandom;
        if (in_mask == '0) in_mask = 32'h1;
        for (int i = 0; i < NUM_IN; i++) in_row[i*4 +: 4] = 4'($urandom_range(0, 3));
        rand_data();
        while (k < 100 && cyc < 5000) begin
            in_valid  = 1'b1;
            out_ready = lfsr[0];
            if (in_ready) begin
                k++;
                step();
                in_mask = $urandom;
                if (in_mask == '0) in_mask = 32'h1;
                for (int i = 0; i < NUM_IN; i++) in_row[i*4 +: 4] = 4'($urandom_range(0, 3));
                rand_data();
            end else begin
                step();
            end
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_sent", k, 100);
        drain("stream_drain");
        chk("stream_q_empty", exp_q.size(), 0);
        chk("stream_out_count", n_out, n_issued);

        // Reset mid-flight discards everything in the pipe.
        out_ready = 1'b1;
        in_mask   = '1;
        in_row    = rows_same;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            rand_data();
            step();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        seen = 0;
        repeat (15) begin
            step();
            if (out_valid || busy) seen = 1;
        end
        chk("midrst_no_out", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
